// File: rtl/class_frame_loader_if.sv
// Byte-stream input and result output handshakes of the frame loader.
// The slave modport is the loader's view; master is the producer/consumer side.
interface class_frame_loader_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic       m_valid;
  logic       m_ready;
  logic       m_class;
  logic       m_err;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_class, m_err
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_class, m_err
  );
endinterface

// File: rtl/class_frame_loader.sv
// Assembles a byte stream into a feature vector for a combinational classifier,
// waits a settle time, samples the class bit and returns it with error status.
module class_frame_loader #(
  parameter int FEAT_W      = 51,
  parameter int EVAL_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  class_frame_loader_if.slave  bus,
  output logic [FEAT_W-1:0]    feat_o,
  input  logic                 cls_i,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic [7:0]           err_cnt
);
  localparam int NB    = (FEAT_W + 7) / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);
  localparam logic [3:0]       EVAL_END = 4'(EVAL_CYCLES);

  typedef enum logic [1:0] {COLLECT, DRAIN, EVAL, RESP} state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [3:0]         cnt, cnt_n;
  logic [FEAT_W-1:0]  feat_n;
  logic               ready_n, valid_n, class_n, err_n;
  logic [CNT_W-1:0]   frame_cnt_n;
  logic [7:0]         err_cnt_n;
  logic               xfer;
  logic [FEAT_W-1:0]  byte_mask, byte_data;

  assign xfer = bus.s_valid & bus.s_ready;
  // Truncation to FEAT_W drops the unused upper bits of the final byte.
  assign byte_mask = FEAT_W'(8'hFF) << {idx, 3'b000};
  assign byte_data = FEAT_W'(bus.s_data) << {idx, 3'b000};

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    cnt_n       = cnt;
    feat_n      = feat_o;
    class_n     = bus.m_class;
    err_n       = bus.m_err;
    frame_cnt_n = frame_cnt;
    err_cnt_n   = err_cnt;
    case (state)
      COLLECT: if (xfer) begin
        feat_n = (feat_o & ~byte_mask) | byte_data;
        idx_n  = idx + 1'b1;
        if (idx == LAST_IDX) begin
          if (bus.s_last) begin
            state_n = EVAL;
            cnt_n   = '0;
          end else begin
            state_n = DRAIN;
          end
        end else if (bus.s_last) begin
          state_n = RESP;
          class_n = 1'b0;
          err_n   = 1'b1;
        end
      end
      DRAIN: if (xfer && bus.s_last) begin
        state_n = RESP;
        class_n = 1'b0;
        err_n   = 1'b1;
      end
      EVAL: begin
        if (cnt == EVAL_END) begin
          state_n = RESP;
          class_n = cls_i;
          err_n   = 1'b0;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      RESP: if (bus.m_ready) begin
        state_n = COLLECT;
        idx_n   = '0;
        if (bus.m_err) begin
          if (err_cnt != 8'hFF) err_cnt_n = err_cnt + 8'd1;
        end else begin
          frame_cnt_n = frame_cnt + 1'b1;
        end
      end
      default: state_n = COLLECT;
    endcase
    // Handshake outputs are registered from the next state, keeping them off
    // any combinational path from s_valid/m_ready.
    ready_n = (state_n == COLLECT) || (state_n == DRAIN);
    valid_n = (state_n == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= COLLECT;
      idx         <= '0;
      cnt         <= '0;
      feat_o      <= '0;
      bus.s_ready <= 1'b0;
      bus.m_valid <= 1'b0;
      bus.m_class <= 1'b0;
      bus.m_err   <= 1'b0;
      frame_cnt   <= '0;
      err_cnt     <= '0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      cnt         <= cnt_n;
      feat_o      <= feat_n;
      bus.s_ready <= ready_n;
      bus.m_valid <= valid_n;
      bus.m_class <= class_n;
      bus.m_err   <= err_n;
      frame_cnt   <= frame_cnt_n;
      err_cnt     <= err_cnt_n;
    end
  end
endmodule

// File: doc/class_frame_loader.md
Name: class_frame_loader

Overview:
- Feeds a combinational decision-tree classifier; it is the upstream end of the classifier's 51-bit feature port.
- Accepts a byte stream over a valid/ready handshake and assembles a 51-bit feature vector. It presents the vector to the classifier, waits a programmable settle time, samples the 1-bit class output, and returns the result over a second valid/ready handshake.
- Malformed frames are detected, drained and reported.

Parameters:
- FEAT_W, 51, feature vector width; bytes per frame NB = ceil(FEAT_W/8) = 7.
- EVAL_CYCLES, 1, cycles the vector is held stable before the class output is sampled (range 1..15).
- CNT_W, 16, width of the good-frame counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  input byte valid.
- s_ready  out  1  loader can accept a byte.
- s_data  in  8  feature byte; byte k maps to feature bits [8k+7:8k].
- s_last  in  1  marks the final byte of a frame.
- feat_o  out  FEAT_W  feature vector driven to the classifier.
- cls_i  in  1  classifier decision.
- m_valid  out  1  result valid.
- m_ready  in  1  result consumer ready.
- m_class  out  1  captured class; 0 on error frames.
- m_err  out  1  result belongs to a malformed frame.
- frame_cnt  out  CNT_W  count of good frames delivered.
- err_cnt  out  8  count of error frames delivered.

Behaviour:
- Reset (async assert, sync release): state=COLLECT, byte index=0, feat_o=0, s_ready=0 during reset, m_valid=0, m_class=0, m_err=0, frame_cnt=0, err_cnt=0.
- A byte transfers on an edge where s_valid and s_ready are both 1.
- s_ready=1 only in COLLECT and DRAIN.
- State COLLECT:
  - Each transfer writes s_data into the feat_o slice for the current index and increments the index.
  - Byte 6 writes only bits [50:48]; s_data[7:3] of that byte is ignored.
  - Transfer at index 6 with s_last=1: frame is good, go to EVAL, settle counter=0.
  - Transfer at index <6 with s_last=1: frame is short. Set m_err=1, m_class=0, go to RESP. The feat_o bytes already written are left as-is.
  - Transfer at index 6 with s_last=0: frame is long. Go to DRAIN.
- State DRAIN:
  - Accept and discard bytes; feat_o is not modified.
  - On a transfer with s_last=1: set m_err=1, m_class=0, go to RESP.
- State EVAL:
  - s_ready=0; feat_o held stable.
  - The settle counter increments each cycle. When it reaches EVAL_CYCLES, on that edge: m_class<=cls_i, m_err<=0, go to RESP.
  - Latency from the edge accepting the last byte to m_valid=1 is EVAL_CYCLES+1 cycles.
- State RESP:
  - m_valid=1. m_class and m_err are held until the edge where m_ready=1.
  - On that edge: m_valid<=0, index<=0, go to COLLECT.
  - Same edge, good frame: frame_cnt increments, wrapping from all-ones to 0.
  - Same edge, error frame: err_cnt increments, saturating at 255.
  - feat_o is held through RESP and is only overwritten by the next frame's bytes.
- No overlap: the next frame's first byte is accepted no earlier than the cycle after m_valid falls.
- m_ready asserted outside RESP has no effect. s_valid asserted outside COLLECT/DRAIN is back-pressured and no data is lost.
- Reset mid-frame or mid-RESP aborts all activity and restores the reset values; no result is emitted for the aborted frame.
- All outputs are registered; there are no combinational paths from s_valid/m_ready to s_ready/m_valid.

Test Plan:
- Good frame: bytes 0x01,0x00,0x00,0x00,0x00,0x00,0x04 (s_last on 7th), cls_i tied to feat_o[50]. Require feat_o=51'h4_0000_0000_0001, m_valid=1 exactly 2 cycles after the last transfer (EVAL_CYCLES=1), m_class=1, m_err=0, frame_cnt=1 after m_ready.
- Byte-6 masking: byte 6 = 0xFF. Require feat_o[50:48]=3'b111, vector width unaffected, m_err=0.
- Short frame: 3 bytes with s_last on the 3rd. Require m_err=1, m_class=0, err_cnt=1, frame_cnt unchanged.
- Long frame: 9 bytes with s_last on the 9th. Require bytes 7–8 accepted and discarded, feat_o equal to bytes 0–6, then m_err=1 and err_cnt increments.
- Back-pressure: hold m_ready=0 for 10 cycles with s_valid=1. Require s_ready=0 throughout and m_class stable; the first byte of the next frame is accepted on the cycle after the m_ready handshake.
- Reset: assert rst_n=0 after 4 bytes of a frame. Require all outputs return to reset values asynchronously; the next full 7-byte frame produces a correct good result with frame_cnt=1.
